// File: rtl/ucca_config.sv
// Configuration window for the UCCA region monitor: two regions' bounds and enables,
// validated on a lock request and frozen until system_reset.
module ucca_config #(
  parameter logic [15:0] CONF_BASE = 16'h0160,
  parameter logic [15:0] CONF_END  = 16'h016B
) (
  input  logic        clk,
  input  logic        system_reset,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_din,
  output logic [15:0] cfg_dout,
  output logic [15:0] ucc0_min,
  output logic [15:0] ucc0_max,
  output logic [15:0] ucc1_min,
  output logic [15:0] ucc1_max,
  output logic [1:0]  ucc_valid,
  output logic        locked,
  output logic        reset
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConfig = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam logic [14:0] BaseW = CONF_BASE[15:1];

  state_e      state_q, state_d;
  logic [15:0] r0_min_q, r0_min_d;
  logic [15:0] r0_max_q, r0_max_d;
  logic [15:0] r1_min_q, r1_min_d;
  logic [15:0] r1_max_q, r1_max_d;
  logic [1:0]  en_q, en_d;
  logic        cfg_error_q, cfg_error_d;
  logic [15:0] dout_q, dout_d;
  logic        reset_q, reset_d;

  logic hit, wr_hit, rd_hit;
  logic sel_r0_min, sel_r0_max, sel_r1_min, sel_r1_max, sel_ctrl, sel_status;
  logic [1:0]  new_en;
  logic        ok0, ok1, no_overlap, lock_ok;
  logic [15:0] rd_val;

  assign hit    = data_en & (data_addr >= CONF_BASE) & (data_addr <= CONF_END) & ~data_addr[0];
  assign wr_hit = hit & data_wr;
  assign rd_hit = hit & ~data_wr;

  assign sel_r0_min = (data_addr[15:1] == BaseW);
  assign sel_r0_max = (data_addr[15:1] == BaseW + 15'd1);
  assign sel_r1_min = (data_addr[15:1] == BaseW + 15'd2);
  assign sel_r1_max = (data_addr[15:1] == BaseW + 15'd3);
  assign sel_ctrl   = (data_addr[15:1] == BaseW + 15'd4);
  assign sel_status = (data_addr[15:1] == BaseW + 15'd5);

  // Lock check uses the stored bounds together with the EN bits being written now.
  assign new_en     = data_din[2:1];
  assign ok0        = (r0_min_q < r0_max_q) & ~r0_min_q[0] & ~r0_max_q[0];
  assign ok1        = (r1_min_q < r1_max_q) & ~r1_min_q[0] & ~r1_max_q[0];
  assign no_overlap = (r0_max_q < r1_min_q) | (r1_max_q < r0_min_q);
  assign lock_ok    = (new_en != 2'b00)
                    & (~new_en[0] | ok0)
                    & (~new_en[1] | ok1)
                    & (~(new_en[0] & new_en[1]) | no_overlap);

  always_comb begin
    state_d     = state_q;
    r0_min_d    = r0_min_q;
    r0_max_d    = r0_max_q;
    r1_min_d    = r1_min_q;
    r1_max_d    = r1_max_q;
    en_d        = en_q;
    cfg_error_d = cfg_error_q;
    reset_d     = 1'b0;
    case (state_q)
      StIdle, StConfig: begin
        if (wr_hit && !sel_status) begin
          state_d = StConfig;
          if (sel_r0_min) r0_min_d = data_din;
          if (sel_r0_max) r0_max_d = data_din;
          if (sel_r1_min) r1_min_d = data_din;
          if (sel_r1_max) r1_max_d = data_din;
          if (sel_ctrl) begin
            en_d = new_en;
            if (data_din[0]) begin
              if (lock_ok) begin
                state_d     = StLocked;
                cfg_error_d = 1'b0;
              end else begin
                cfg_error_d = 1'b1;
              end
            end
          end
        end
      end
      StLocked: reset_d = wr_hit;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_val = 16'h0000;
    if (sel_r0_min) rd_val = r0_min_q;
    if (sel_r0_max) rd_val = r0_max_q;
    if (sel_r1_min) rd_val = r1_min_q;
    if (sel_r1_max) rd_val = r1_max_q;
    if (sel_ctrl)   rd_val = {13'd0, en_q, locked};
    if (sel_status) rd_val = {13'd0, cfg_error_q, state_q};
    dout_d = rd_hit ? rd_val : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q     <= StIdle;
      r0_min_q    <= 16'h0000;
      r0_max_q    <= 16'h0000;
      r1_min_q    <= 16'h0000;
      r1_max_q    <= 16'h0000;
      en_q        <= 2'b00;
      cfg_error_q <= 1'b0;
      dout_q      <= 16'h0000;
      reset_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_min_q    <= r0_min_d;
      r0_max_q    <= r0_max_d;
      r1_min_q    <= r1_min_d;
      r1_max_q    <= r1_max_d;
      en_q        <= en_d;
      cfg_error_q <= cfg_error_d;
      dout_q      <= dout_d;
      reset_q     <= reset_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign ucc_valid = en_q & {2{locked}};
  assign ucc0_min  = r0_min_q;
  assign ucc0_max  = r0_max_q;
  assign ucc1_min  = r1_min_q;
  assign ucc1_max  = r1_max_q;
  assign cfg_dout  = dout_q;
  assign reset     = reset_q;

endmodule

// File: tb/tb_ucca_config.sv
// Bench for ucca_config: read expectations go through a scoreboard queue, everything else
// is compared directly against bench-computed constants.
module tb_ucca_config;

  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic        data_en = 1'b0;
  logic        data_wr = 1'b0;
  logic [15:0] data_addr = 16'h0000;
  logic [15:0] data_din = 16'h0000;
  logic [15:0] cfg_dout, ucc0_min, ucc0_max, ucc1_min, ucc1_max;
  logic [1:0]  ucc_valid;
  logic        locked, reset;

  ucca_config dut (
    .clk          (clk),
    .system_reset (system_reset),
    .data_en      (data_en),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_din     (data_din),
    .cfg_dout     (cfg_dout),
    .ucc0_min     (ucc0_min),
    .ucc0_max     (ucc0_max),
    .ucc1_min     (ucc1_min),
    .ucc1_max     (ucc1_max),
    .ucc_valid    (ucc_valid),
    .locked       (locked),
    .reset        (reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int  n_total = 0;
  int  n_bad   = 0;
  bit  rd_push = 1'b0;
  bit  mon_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cfg_dout is registered, so a read driven before posedge is visible just after it.
  always begin
    @(posedge clk);
    mon_pend = rd_push;
    #1;
    if (mon_pend) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check_eq(it.tag, {16'd0, cfg_dout}, {16'd0, it.exp});
      end
    end
  end

  task automatic wr(input logic [15:0] addr, input logic [15:0] din);
    @(negedge clk);
    data_en = 1'b1; data_wr = 1'b1; data_addr = addr; data_din = din;
    @(negedge clk);
    data_en = 1'b0; data_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    sb_item_t it;
    @(negedge clk);
    data_en = 1'b1; data_wr = 1'b0; data_addr = addr;
    it.tag = tag; it.exp = exp;
    sb_q.push_back(it);
    rd_push = 1'b1;
    @(negedge clk);
    data_en = 1'b0; rd_push = 1'b0;
  endtask

  task automatic sys_rst();
    @(negedge clk);
    system_reset = 1'b1;
    @(negedge clk);
    system_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    system_reset = 1'b0;
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_valid", {30'd0, ucc_valid}, 32'd0);
    check_eq("rst_pulse", {31'd0, reset}, 32'd0);
    for (int i = 0; i < 6; i++) rd($sformatf("rst_rd%0d", i), 16'h0160 + 16'(2 * i), 16'h0000);

    // Valid lock of region 0
    wr(16'h0160, 16'hE000);
    wr(16'h0162, 16'hE0FE);
    check_eq("pre_lock_valid", {30'd0, ucc_valid}, 32'd0);
    wr(16'h0168, 16'h0003);
    check_eq("lock_locked", {31'd0, locked}, 32'd1);
    check_eq("lock_valid", {30'd0, ucc_valid}, 32'd1);
    check_eq("lock_min", {16'd0, ucc0_min}, 32'hE000);
    rd("lock_status", 16'h016A, 16'h0002);
    rd("lock_ctrl", 16'h0168, 16'h0003);
    rd("odd_read", 16'h0161, 16'h0000);
    rd("out_read", 16'h0200, 16'h0000);

    // Violation while locked
    wr(16'h0160, 16'h1234);
    check_eq("viol_pulse", {31'd0, reset}, 32'd1);
    @(negedge clk);
    check_eq("viol_pulse_end", {31'd0, reset}, 32'd0);
    rd("viol_frozen", 16'h0160, 16'hE000);
    wr(16'h0200, 16'h5555);
    check_eq("out_wr_nopulse", {31'd0, reset}, 32'd0);
    wr(16'h0161, 16'h5555);
    check_eq("odd_wr_nopulse", {31'd0, reset}, 32'd0);

    // Back-to-back violations, the second to STATUS
    @(negedge clk);
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0162; data_din = 16'h0000;
    @(negedge clk);
    data_addr = 16'h016A;
    check_eq("b2b_pulse0", {31'd0, reset}, 32'd1);
    @(negedge clk);
    data_en = 1'b0; data_wr = 1'b0;
    check_eq("b2b_pulse1", {31'd0, reset}, 32'd1);
    @(negedge clk);
    check_eq("b2b_end", {31'd0, reset}, 32'd0);
    check_eq("b2b_max", {16'd0, ucc0_max}, 32'hE0FE);

    // system_reset together with a violating write
    @(negedge clk);
    system_reset = 1'b1;
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0160; data_din = 16'h1234;
    @(negedge clk);
    system_reset = 1'b0; data_en = 1'b0; data_wr = 1'b0;
    check_eq("sim_pulse", {31'd0, reset}, 32'd0);
    check_eq("sim_locked", {31'd0, locked}, 32'd0);
    check_eq("sim_min", {16'd0, ucc0_min}, 32'h0000);
    check_eq("sim_valid", {30'd0, ucc_valid}, 32'd0);
    rd("sim_status", 16'h016A, 16'h0000);

    // Invalid lock (min > max), then fixed
    wr(16'h0160, 16'hE100);
    wr(16'h0162, 16'hE000);
    wr(16'h0168, 16'h0003);
    check_eq("bad_locked", {31'd0, locked}, 32'd0);
    check_eq("bad_valid", {30'd0, ucc_valid}, 32'd0);
    rd("bad_status", 16'h016A, 16'h0005);
    wr(16'h016A, 16'h0000);
    rd("status_ro", 16'h016A, 16'h0005);
    wr(16'h0162, 16'hE1FE);
    wr(16'h0168, 16'h0003);
    rd("fix_status", 16'h016A, 16'h0002);

    // Overlap rejection, then disjoint regions lock
    sys_rst();
    wr(16'h0160, 16'hE000);
    wr(16'h0162, 16'hE0FE);
    wr(16'h0164, 16'hE0F0);
    wr(16'h0166, 16'hE200);
    wr(16'h0168, 16'h0007);
    check_eq("ovl_locked", {31'd0, locked}, 32'd0);
    rd("ovl_status", 16'h016A, 16'h0005);
    wr(16'h0164, 16'hE100);
    wr(16'h0168, 16'h0007);
    check_eq("two_valid", {30'd0, ucc_valid}, 32'd3);
    check_eq("two_r1min", {16'd0, ucc1_min}, 32'hE100);
    check_eq("two_r1max", {16'd0, ucc1_max}, 32'hE200);
    rd("two_ctrl", 16'h0168, 16'h0007);

    // Odd bound and no-region lock requests both fail
    sys_rst();
    wr(16'h0160, 16'hE001);
    wr(16'h0162, 16'hE0FE);
    wr(16'h0168, 16'h0003);
    rd("odd_bound_status", 16'h016A, 16'h0005);
    wr(16'h0160, 16'hE000);
    wr(16'h0168, 16'h0001);
    check_eq("noen_locked", {31'd0, locked}, 32'd0);
    rd("noen_status", 16'h016A, 16'h0005);

    @(negedge clk);
    check_eq("sb_left", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ucca_config.md
Name: ucca_config

Overview:
- Memory-mapped configuration stage directly upstream of the UCCA region monitor.
- Holds up to two UCC regions' min/max bounds and enable bits in a word-addressed window at CONF_BASE..CONF_END.
- Validates the configuration on a lock request, then freezes it until system reset.
- Drives ucc_min/ucc_max and a per-region valid flag to the region monitors, and raises a one-cycle reset on any write to the window while locked.

Parameters:
- CONF_BASE, 16'h0160, byte address of first config word.
- CONF_END, 16'h016B, byte address of last config byte (6 words total).

Ports:
- clk  input  1  system clock
- system_reset  input  1  synchronous, active-high reset; clears all state
- data_en  input  1  data bus access strobe
- data_wr  input  1  1 = write, 0 = read (qualified by data_en)
- data_addr  input  16  byte address
- data_din  input  16  write data
- cfg_dout  output  16  registered read data for window reads
- ucc0_min  output  16  region 0 lower bound
- ucc0_max  output  16  region 0 upper bound
- ucc1_min  output  16  region 1 lower bound
- ucc1_max  output  16  region 1 upper bound
- ucc_valid  output  2  bit n = region n enabled AND locked
- locked  output  1  configuration frozen
- reset  output  1  violation pulse, ORed into the system reset by the top level

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the posedge of clk.
  - System_reset (synchronous) clears all registers and outputs to 0 and sets the state to IDLE.
- Register map (word-aligned; data_addr[0]=1 accesses are ignored):
  - +0x0 R0_MIN
  - +0x2 R0_MAX
  - +0x4 R1_MIN
  - +0x6 R1_MAX
  - +0x8 CTRL: bit0 LOCK, bit1 R0_EN, bit2 R1_EN
  - +0xA STATUS (read-only): [1:0] state, bit2 cfg_error
- Hit definition: hit = data_en & CONF_BASE <= data_addr <= CONF_END & ~data_addr[0].
- Reads:
  - A read hit in cycle t presents the register value on cfg_dout in cycle t+1.
  - cfg_dout is 0 in any cycle not following a read hit.
  - CTRL reads back bit0 = locked.
- State machine (encoding 0/1/2):
  - IDLE(0): the first write hit to any writable register moves to CONFIG. That write also takes effect.
  - CONFIG(1):
    - A write to MIN/MAX updates that register in the next cycle.
    - A write to CTRL latches the EN bits. If LOCK=1, a lock check runs on the stored bounds and the newly written EN bits.
    - Lock check conditions, for each enabled region: min < max (unsigned), min[0] = 0, max[0] = 0.
    - If both regions are enabled, additionally require no overlap: r0_max < r1_min OR r1_max < r0_min.
    - Check passes: move to LOCKED at the next edge and clear cfg_error.
    - Check fails: stay in CONFIG and set cfg_error (sticky until a successful lock or system_reset).
    - A lock request with no region enabled fails.
    - Writes to STATUS are ignored.
  - LOCKED(2):
    - All registers are frozen.
    - Any write hit, including to STATUS, leaves the registers unchanged and asserts reset for exactly one cycle, in cycle t+1.
    - Reads remain allowed.
    - Only system_reset leaves LOCKED.
- Outputs:
  - ucc*_min and ucc*_max always mirror the registers.
  - ucc_valid = {R1_EN & locked, R0_EN & locked}; it is 0 before lock.
  - The region monitors must treat ucc_valid = 0 as "no region".
- Simultaneous events:
  - system_reset in the same cycle as a violating write: reset stays 0 and all state clears.
  - Back-to-back violating writes produce back-to-back reset pulses.
- Non-hit accesses (outside the window or odd address) never change state and never pulse reset.

Test Plan:
- Reset then reads: system_reset, then read 0x0160..0x016A -> cfg_dout = 0 for all; ucc_valid = 0; locked = 0; STATUS = 0.
- Valid lock: write R0_MIN=0xE000, R0_MAX=0xE0FE, then CTRL=0x0003 -> next cycle locked = 1, ucc_valid = 2'b01, STATUS = 0x0002, ucc0_min = 0xE000.
- Invalid lock: write R0_MIN=0xE100, R0_MAX=0xE000, then CTRL=0x0003 -> locked = 0, STATUS = 0x0005, ucc_valid = 0. Fixing R0_MAX=0xE1FE and relocking -> STATUS = 0x0002.
- Overlap rejection: R0 = 0xE000..0xE0FE, R1 = 0xE0F0..0xE200, CTRL=0x0007 -> cfg_error = 1, not locked.
- Locked violation: after a valid lock, write 0x0160 = 0x1234 -> reset high for exactly one cycle, R0_MIN still 0xE000. Writes to 0x0200 and to odd address 0x0161 -> no pulse.
- Simultaneous events: system_reset asserted in the same cycle as a locked write -> reset = 0, state IDLE, all outputs 0.
